lane_accumulator: RTL and testbench

LANE_ACCUMULATOR -- requirements
Module: lane_accumulator

---
 rtl/lane_acc_pkg.sv | 23 ++
 rtl/lane_add_stage.sv | 32 +++
 rtl/lane_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_lane_accumulator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_acc_pkg.sv
// Shared types and widths for the lane accumulator.
// Optional avg output is enabled by LANE_ACC_AVG_EN.
package lane_acc_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int SUM_W  = 32;
  localparam int RED_W  = LANE_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic [SUM_W-1:0] widen(
    input logic [RED_W-1:0] v
  );
    return {{(SUM_W-RED_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/lane_add_stage.sv
// One registered level of the pairwise lane reduction tree.
// Adjacent input pairs are summed one bit wider than the inputs.
module lane_add_stage #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*W-1:0]         din,
  output logic [(N/2)*(W+1)-1:0] dout
);

  logic [(N/2)*(W+1)-1:0] pair_sum;

  always_comb begin
    pair_sum = '0;
    for (int i = 0; i < N/2; i++) begin
      pair_sum[i*(W+1) +: W+1] =
        {1'b0, din[(2*i)*W +: W]} +
        {1'b0, din[(2*i+1)*W +: W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= pair_sum;
    end
  end

endmodule

// File: rtl/lane_accumulator.sv
// Frame accumulator: sums 8 byte lanes per beat over a frame.
// Define LANE_ACC_AVG_EN to add the rounded avg output.
module lane_accumulator
  import lane_acc_pkg::*;
#(
  parameter int BEATS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic [7:0]  in4,
  input  logic [7:0]  in5,
  input  logic [7:0]  in6,
  input  logic [7:0]  in7,
  output logic [31:0] sum,
  output logic        done,
  output logic [7:0]  beat_cnt,
`ifdef LANE_ACC_AVG_EN
  output logic [7:0]  avg,
`endif
  output logic        busy
);

  localparam logic [7:0] LAST_CNT = 8'(BEATS - 1);

  state_t state;
  state_t state_n;

  logic start;
  logic accept;
  logic fire;
  logic pipe_empty;

  logic [2:0] pipe_vld;

  logic [LANES*LANE_W-1:0]   lane_bus;
  logic [4*(LANE_W+1)-1:0]   s1;
  logic [2*(LANE_W+2)-1:0]   s2;
  logic [RED_W-1:0]          s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_n = ACCUM;
      end
      ACCUM: begin
        if (!in_valid) begin
          state_n = DRAIN;
        end else if (beat_cnt == LAST_CNT) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_n = HOLD;
      end
      HOLD: begin
        if (!in_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    accept = 1'b0;
    fire   = 1'b0;
    busy   = 1'b1;
    unique case (1'b1)
      (state == IDLE): begin
        busy   = 1'b0;
        start  = in_valid;
        accept = in_valid;
      end
      (state == ACCUM): begin
        accept = in_valid;
      end
      (state == DRAIN): begin
        fire = pipe_empty;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Rejected beats enter the tree as zero bubbles.
  assign lane_bus = accept ?
    {in7, in6, in5, in4, in3, in2, in1, in0} : '0;

  assign pipe_empty = (pipe_vld == 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld <= {pipe_vld[1:0], accept};
    end
  end

  lane_add_stage #(
    .N (LANES),
    .W (LANE_W)
  ) u_add_l1 (
    .clk  (clk),
    .rst  (rst),
    .din  (lane_bus),
    .dout (s1)
  );

  lane_add_stage #(
    .N (LANES/2),
    .W (LANE_W+1)
  ) u_add_l2 (
    .clk  (clk),
    .rst  (rst),
    .din  (s1),
    .dout (s2)
  );

  lane_add_stage #(
    .N (LANES/4),
    .W (LANE_W+2)
  ) u_add_l3 (
    .clk  (clk),
    .rst  (rst),
    .din  (s2),
    .dout (s3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (start) begin
      sum <= '0;
    end else begin
      sum <= sum + widen(s3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= 8'd1;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= fire;
    end
  end

`ifdef LANE_ACC_AVG_EN
  // Bits [15:8] of sum+128 is sum[15:8] plus the rounding carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg <= '0;
    end else if (fire) begin
      avg <= sum[15:8] + {7'b0, sum[7]};
    end
  end
`endif

endmodule

// File: tb/tb_lane_accumulator.sv
// Randomised and directed bench for lane_accumulator.
// Frame-level reference model, checked every cycle.
module tb_lane_accumulator;

  localparam int BEATS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] lanes = '0;
  logic [31:0] sum;
  logic        done;
  logic [7:0]  beat_cnt;
  logic        busy;
`ifdef LANE_ACC_AVG_EN
  logic [7:0]  avg;
`endif

  always #5 clk = ~clk;

  lane_accumulator #(
    .BEATS (BEATS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in0      (lanes[7:0]),
    .in1      (lanes[15:8]),
    .in2      (lanes[23:16]),
    .in3      (lanes[31:24]),
    .in4      (lanes[39:32]),
    .in5      (lanes[47:40]),
    .in6      (lanes[55:48]),
    .in7      (lanes[63:56]),
    .sum      (sum),
    .done     (done),
    .beat_cnt (beat_cnt),
`ifdef LANE_ACC_AVG_EN
    .avg      (avg),
`endif
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  int          k = 0;
  bit          collecting = 1'b0;
  bit          armed = 1'b1;
  int          cnt = 0;
  int          last = -100;
  int          done_edge = -100;
  logic [31:0] fsum = '0;
  logic [31:0] final_sum = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (edge %0d)",
               tag, got, exp, k);
    end
  endtask

  function automatic logic [31:0] lane_total(input logic [63:0] l);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t += 32'(l[i*8 +: 8]);
    return t;
  endfunction

  // Frame rules: a frame ends on a low beat or on the BEATS-th beat;
  // done follows the last beat by 4 edges; a new frame needs a low
  // beat sampled at least 5 edges after the last beat.
  task automatic model_edge(input bit v, input logic [63:0] l);
    if (collecting) begin
      if (v) begin
        fsum += lane_total(l);
        cnt++;
        if (cnt == BEATS) begin
          collecting = 1'b0;
          last = k;
          done_edge = k + 4;
          final_sum = fsum;
        end
      end else begin
        collecting = 1'b0;
        last = k - 1;
        done_edge = last + 4;
        final_sum = fsum;
      end
    end else if (armed) begin
      if (v) begin
        collecting = 1'b1;
        armed = 1'b0;
        cnt = 1;
        fsum = lane_total(l);
      end
    end else if (k >= last + 5 && !v) begin
      armed = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [63:0] l);
    bit exp_done;
    @(negedge clk);
    in_valid = v;
    lanes = l;
    @(posedge clk);
    k++;
    model_edge(v, l);
    #1;
    exp_done = (k == done_edge);
    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("busy", {31'b0, busy}, {31'b0, collecting || !armed});
    chk("beat_cnt", {24'b0, beat_cnt}, 32'(cnt));
    if (exp_done || (!collecting && armed))
      chk("sum", sum, final_sum);
`ifdef LANE_ACC_AVG_EN
    if (exp_done)
      chk("avg", {24'b0, avg}, ((final_sum + 32'd128) >> 8) & 32'hFF);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_sum", sum, 32'd0);
    chk("rst_cnt", {24'b0, beat_cnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
`ifdef LANE_ACC_AVG_EN
    chk("rst_avg", {24'b0, avg}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    collecting = 1'b0;
    armed = 1'b1;
    cnt = 0;
    fsum = '0;
    final_sum = '0;
    last = -100;
    done_edge = -100;
  endtask

  initial begin
    do_reset();

    repeat (32) step(1'b1, {8{8'hFF}});
    idle(8);
    chk("r028_sum", sum, 32'd65280);
    chk("r028_cnt", {24'b0, beat_cnt}, 32'd32);
`ifdef LANE_ACC_AVG_EN
    chk("r028_avg", {24'b0, avg}, 32'd255);
`endif

    repeat (32) step(1'b1, {8{8'h01}});
    idle(8);
    chk("r029_sum", sum, 32'd256);
`ifdef LANE_ACC_AVG_EN
    chk("r029_avg", {24'b0, avg}, 32'd1);
`endif

    step(1'b1, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    idle(8);
    chk("r030_sum", sum, 32'd36);
    chk("r030_cnt", {24'b0, beat_cnt}, 32'd1);

    repeat (40) step(1'b1, {8{8'h01}});
    idle(8);
    chk("r031_sum", sum, 32'd256);
    chk("r031_cnt", {24'b0, beat_cnt}, 32'd32);

    repeat (10) step(1'b1, {$urandom, $urandom});
    do_reset();
    repeat (4) step(1'b1, {8{8'h02}});
    idle(8);
    chk("r032_sum", sum, 32'd64);
    chk("r032_cnt", {24'b0, beat_cnt}, 32'd4);

    repeat (12) begin
      step(1'b1, {$urandom, $urandom});
      step(1'b0, '0);
    end
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else if (((i / 300) % 2) == 1) begin
        step($urandom_range(0, 49) != 0, {$urandom, $urandom});
      end else begin
        step($urandom_range(0, 3) != 0, {$urandom, $urandom});
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
